// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, polarity normalisation and a counter-based
// debounce FSM with registered level and press/release strobes. Define BTN_AUTOREPEAT_EN for hold-to-repeat.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            s;
    logic            repeat_fire;

    // Normalised synchronised button: 1 = pressed regardless of pad polarity.
    assign s = sync2_q ^ ACTIVE_LOW;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HoldW = (HoldMax > 2) ? $clog2(HoldMax) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0] RepeatLast = HoldW'(REPEAT_CYCLES - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             rep_q, rep_d;

    // rep_q selects the inter-repeat period once the initial hold delay has elapsed.
    always_comb begin
        hold_d      = '0;
        rep_d       = 1'b0;
        repeat_fire = 1'b0;
        if (state_q == StPressed && s) begin
            if (rep_q ? (hold_q == RepeatLast) : (hold_q == HoldLast)) begin
                repeat_fire = 1'b1;
                rep_d       = 1'b1;
            end else begin
                hold_d = (hold_q == '1) ? hold_q : hold_q + HoldW'(1);
                rep_d  = rep_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (s) begin
                    state_d = StPressWait;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StPressWait: begin
                if (!s) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
                end
            end
            StPressed: begin
                if (!s) begin
                    state_d = StReleaseWait;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d   = '0;
                    press_d = repeat_fire;
                end
            end
            StReleaseWait: begin
                if (s) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StReleased;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            state_q <= StReleased;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule
